// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants and feed state type for the sigma-delta dac path
package dac_pkg;

    localparam int DAC_DW        = 16;
    localparam int DAC_OSR       = 6;
    localparam int DAC_RAMP_STEP = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/dac_tick_gen.sv
// rtl/dac_tick_gen.sv - free-running OSR-bit counter, pulses once per sample period
module dac_tick_gen
    import dac_pkg::*;
#(
    parameter int OSR = DAC_OSR
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [OSR-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = &count;

endmodule

// File: rtl/dac_feed_ctrl.sv
// rtl/dac_feed_ctrl.sv - pulls one PCM sample per period into the dac, slewing to/from zero on enable changes
module dac_feed_ctrl
    import dac_pkg::*;
#(
    parameter int DW        = DAC_DW,
    parameter int OSR       = DAC_OSR,
    parameter int RAMP_STEP = DAC_RAMP_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic signed [DW-1:0] dac_din,
    output logic                 sample_tick,
    output logic                 underrun,
    output logic [15:0]          underrun_cnt,
    output logic                 active
);

    localparam logic signed [DW:0] STEP = (DW+1)'(RAMP_STEP);

    // One extra bit keeps tgt - cur exact across the full signed range.
    function automatic logic signed [DW-1:0] slew(input logic signed [DW-1:0] cur,
                                                  input logic signed [DW-1:0] tgt);
        logic signed [DW:0] cur_w;
        logic signed [DW:0] diff;
        cur_w = {cur[DW-1], cur};
        diff  = {tgt[DW-1], tgt} - cur_w;
        if (diff > STEP) begin
            slew = DW'(cur_w + STEP);
        end else if (diff < -STEP) begin
            slew = DW'(cur_w - STEP);
        end else begin
            slew = tgt;
        end
    endfunction

    feed_state_t          state, state_next;
    logic signed [DW-1:0] target, target_next;
    logic signed [DW-1:0] din_next;
    logic signed [DW-1:0] start_goal;
    logic                 underrun_next;

    dac_tick_gen #(.OSR(OSR)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (sample_tick)
    );

    assign s_ready    = sample_tick & enable & ((state == START) | (state == RUN));
    assign start_goal = s_valid ? s_data : target;
    assign active     = (state != IDLE);

    always_comb begin
        state_next    = state;
        target_next   = target;
        din_next      = dac_din;
        underrun_next = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_next  = START;
                        target_next = '0;
                    end
                end
                START: begin
                    if (!enable) begin
                        state_next = STOP;
                        din_next   = slew(dac_din, '0);
                    end else begin
                        target_next   = start_goal;
                        din_next      = slew(dac_din, start_goal);
                        underrun_next = !s_valid;
                        if (din_next == start_goal) begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_next = STOP;
                        din_next   = slew(dac_din, '0);
                    end else if (s_valid) begin
                        din_next = s_data;
                    end else begin
                        underrun_next = 1'b1;
                    end
                end
                STOP: begin
                    // Re-enable resumes from the current level; no step is taken on this tick.
                    if (enable) begin
                        state_next  = START;
                        target_next = '0;
                    end else begin
                        din_next = slew(dac_din, '0);
                        if (din_next == '0) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target       <= '0;
            dac_din      <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state    <= state_next;
            target   <= target_next;
            dac_din  <= din_next;
            underrun <= underrun_next;
            if (underrun_next && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_feed_ctrl.sv
// tb/tb_dac_feed_ctrl.sv - randomized bench for dac_feed_ctrl against a behavioural sample-scheduler model
module tb_dac_feed_ctrl;

    logic               clk;
    logic               rst;
    logic               enable;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] dac_din;
    logic               sample_tick;
    logic               underrun;
    logic [15:0]        underrun_cnt;
    logic               active;

    int n_cmp = 0;
    int n_bad = 0;

    dac_feed_ctrl #(.DW(16), .OSR(6), .RAMP_STEP(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dac_din      (dac_din),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 silent, 1 ramping in, 2 streaming, 3 ramping out.
    int m_phase  = 0;
    int m_mode   = 0;
    int m_din    = 0;
    int m_goal   = 0;
    int m_under  = 0;
    int m_ucnt   = 0;

    function automatic int toward(input int cur, input int goal);
        int d;
        d = goal - cur;
        if (d > 64)  return cur + 64;
        if (d < -64) return cur - 64;
        return goal;
    endfunction

    initial begin
        bit tick;
        bit rdy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            tick = (m_phase == 63);
            rdy  = tick && enable && (m_mode == 1 || m_mode == 2);
            check("sample_tick",  int'(sample_tick), int'(tick));
            check("s_ready",      int'(s_ready), int'(rdy));
            check("dac_din",      int'(dac_din), m_din);
            check("underrun",     int'(underrun), m_under);
            check("underrun_cnt", int'(underrun_cnt), m_ucnt);
            check("active",       int'(active), int'(m_mode != 0));
            if (rst) begin
                m_phase = 0; m_mode = 0; m_din = 0; m_goal = 0; m_under = 0; m_ucnt = 0;
            end else begin
                m_phase = (m_phase + 1) % 64;
                m_under = 0;
                if (tick) begin
                    if (m_mode == 0) begin
                        if (enable) begin m_mode = 1; m_goal = 0; end
                    end else if (m_mode == 3) begin
                        if (enable) begin
                            m_mode = 1; m_goal = 0;
                        end else begin
                            m_din = toward(m_din, 0);
                            if (m_din == 0) m_mode = 0;
                        end
                    end else if (!enable) begin
                        m_mode = 3;
                        m_din  = toward(m_din, 0);
                    end else if (m_mode == 1) begin
                        if (s_valid) m_goal = int'(s_data);
                        else m_under = 1;
                        m_din = toward(m_din, m_goal);
                        if (m_din == m_goal) m_mode = 2;
                    end else begin
                        if (s_valid) m_din = int'(s_data);
                        else m_under = 1;
                    end
                    if (m_under == 1 && m_ucnt < 65535) m_ucnt++;
                end
            end
        end
    end

    task automatic next_tick(output int val);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sample_tick) break;
            n++;
            if (n > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tick_wait: got no sample_tick in 300 cycles, expected one every 64");
                break;
            end
        end
        @(posedge clk);
        #1;
        val = int'(dac_din);
    endtask

    task automatic count_to_tick(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (sample_tick || n > 200) break;
            n++;
        end
    endtask

    int d_en  [0:17] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    int d_dat [0:17] = '{264, 264, 264, 264, 264, 264, 264, 32767, 32767, 32767, 32767,
                         400, -32768, -32768, 32767, 32767, 32767, -32600};
    int d_exp [0:17] = '{0, 64, 128, 192, 256, 264, 200, 200, 264, 328, 392,
                         400, -32768, -32704, -32704, -32640, -32576, -32600};
    int stop_exp [0:4] = '{-236, -172, -108, -44, 0};

    initial begin
        int v;
        int n;
        bit acc;
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        count_to_tick(n);
        check("first_tick_cycle", n, 63);

        repeat (900) begin
            @(posedge clk); #1;
            s_valid = 1'($urandom_range(0, 1));
        end

        enable = 1'b1; s_valid = 1'b1; s_data = 16'sd1000;
        for (int k = 0; k <= 16; k++) begin
            next_tick(v);
            check($sformatf("ramp_in_%0d", k), v, (k < 16) ? k * 64 : 1000);
        end
        check("run_active", int'(active), 1);

        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_tick(v);
            check($sformatf("underrun_hold_%0d", k), v, 1000);
        end
        check("underrun_pulse", int'(underrun), 1);
        check("underrun_total", int'(underrun_cnt), 3);
        s_valid = 1'b1; s_data = -16'sd300;
        next_tick(v);
        check("resume_sample", v, -300);

        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_tick(v);
            check($sformatf("ramp_out_%0d", k), v, stop_exp[k]);
        end
        check("idle_after_stop", int'(active), 0);

        for (int k = 0; k < 18; k++) begin
            enable = 1'(d_en[k]);
            s_data = 16'(d_dat[k]);
            next_tick(v);
            check($sformatf("slew_step_%0d", k), v, d_exp[k]);
        end
        check("extreme_run_active", int'(active), 1);

        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_dac_din", int'(dac_din), 0);
        check("rst_active", int'(active), 0);
        check("rst_underrun_cnt", int'(underrun_cnt), 0);
        rst = 1'b0;
        count_to_tick(n);
        check("tick_phase_restart", n, 63);

        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            acc = s_ready && s_valid;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 1499) == 0) enable = ~enable;
            if (!s_valid || acc) begin
                s_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) s_data = 16'($urandom);
                else s_data = 16'($urandom_range(0, 399)) - 16'sd200;
            end
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_feed_ctrl.md
# dac_feed_ctrl

Sample scheduler that sits in front of the second-order sigma-delta `dac` and feeds it one PCM sample per oversampling period. It pulls samples from an upstream valid/ready stream at the DAC sample rate and holds the last value on underrun. On enable and disable it slews the DAC input to and from zero, so the analog output never steps and never pops.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `OSR`, 6: log2 of the sample period; one sample every 2^OSR clk cycles.
- `RAMP_STEP`, 64: maximum |change| of `dac_din` per sample period in START/STOP.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  request playback; low requests a soft stop.
- `s_data`  in  DW  signed input sample.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  sample accepted this cycle (combinational).
- `dac_din`  out  DW  signed sample to `dac.din`, registered.
- `sample_tick`  out  1  one-cycle pulse per sample period.
- `underrun`  out  1  one-cycle pulse: tick in START/RUN with `s_valid` low.
- `underrun_cnt`  out  16  saturating underrun count.
- `active`  out  1  state != IDLE.

## Operation
- Tick counter, OSR bits, free-running from reset; `sample_tick` = (count == 2^OSR−1).
- State transitions and `dac_din` updates occur only on tick cycles. Between ticks, all outputs hold except the counter.
- States:
  - IDLE: `dac_din` = 0, `s_ready` = 0. On tick with `enable` = 1, go to START.
  - START: the accepted sample becomes the target. `dac_din` moves toward the target by min(|target − dac_din|, RAMP_STEP). If |target − dac_din| ≤ RAMP_STEP, `dac_din` = target exactly and the state goes to RUN.
  - RUN: an accepted sample is copied directly to `dac_din`.
  - STOP: `s_ready` = 0. `dac_din` moves toward 0 by at most RAMP_STEP. When it reaches 0, go to IDLE.
- `s_ready` = `sample_tick` & `s_valid`-independent & `enable` & (state ∈ {START, RUN}).
- Acceptance is `s_ready & s_valid`. Upstream must hold `s_data` stable while `s_valid` is high.
- Underrun (tick, state ∈ {START, RUN}, `enable` = 1, `s_valid` = 0):
  - RUN holds `dac_din`.
  - START keeps slewing toward the previous target, which is 0 if no sample has been accepted yet.
  - `underrun` pulses and `underrun_cnt` increments, saturating at 0xFFFF.
- `enable` = 0 at a tick in START or RUN: no sample is accepted, the state goes to STOP, and the first slew step toward 0 is applied in that same tick.
- `enable` = 1 at a tick in STOP: go to START and slew from the current `dac_din`. No discontinuity is allowed.
- Arithmetic: difference target − `dac_din` is computed at DW+1 bits signed to avoid overflow. The step result always stays within [min(start, target), max(start, target)] and never overshoots or wraps.

## Timing
- Reset values: state IDLE, counter 0, `dac_din` 0, `s_ready` 0, `sample_tick` 0, `underrun` 0, `underrun_cnt` 0, `active` 0.
- `rst` asserted mid-operation forces reset values on the next edge. It does not slew; a pop is accepted on a hard reset.
- First `sample_tick` comes 2^OSR−1 cycles after the cycle in which `rst` deasserts. After that, one tick every 2^OSR cycles exactly.
- Latency: a sample accepted at tick cycle T appears on `dac_din` at T+1. `underrun` and the `underrun_cnt` update are also registered to T+1.
- `active` reflects the registered state and changes at T+1 of the transition tick.

## Structure
- Shared package `dac_pkg`:
  - State enum `feed_state_t` {IDLE, START, RUN, STOP}.
  - Default `DW`/`OSR` constants, shared with `dac`.
- One sub-module, `dac_tick_gen`: OSR-bit counter producing `sample_tick`.
- The slew step is a local combinational function; there is no further hierarchy.

## Test plan
- Reset, then `enable` = 0 for 1000 cycles: `dac_din` = 0 throughout, `sample_tick` every 64 cycles with the first at cycle 63, `s_ready` never high.
- `enable` = 1 with a constant sample 1000 always valid: `dac_din` steps 0, 64, 128, … 960, then 1000 on tick 16. After that the state is RUN and every tick accepts.
- In RUN, `s_valid` low for 3 ticks: `dac_din` holds, `underrun` pulses 3×, `underrun_cnt` = 3. The next valid sample appears one cycle after its tick.
- Drop `enable` in RUN at `dac_din` = −300: values −236, −172, −108, −44, 0, then IDLE. `s_ready` stays 0 throughout.
- Reassert `enable` during STOP at `dac_din` = 200 with sample 32767: START slews upward from 200 by 64 per tick, with no step larger than 64. Extreme input −32768 → 32767 produces no wrap.
- Assert `rst` mid-RUN: all outputs take reset values on the next edge, and the tick phase restarts at 0.
